hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage RV32 core; it is the consumer end of the control pipeline's hazard-facing outputs. It takes stage register addresses plus the controller's `PCSrcE`, `ResultSrcb0E`, `RegWriteM` and `RegWriteW`. It returns operand-forwarding selects and per-stage stall/flush, including `FlushE` back to the controller. It also owns a data-memory wait state machine with a timeout watchdog, so slow data memory stalls the pipeline instead of corrupting it.

---
 rtl/hazard_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline hazard controller for the 5-stage RV32 core. Produces operand
//   forwarding selects, per-stage stall/flush controls and owns the
//   data-memory wait FSM with a timeout watchdog.
//
// Parameters
//   MEM_TIMEOUT     stalled cycles tolerated in one data-memory wait before the
//                   sticky error trap (2..255, default 16).
//
// Build options
//   HAZARD_PERF_EN  when defined, oStallCycles/oFlushCount are live saturating
//                   counters; otherwise they are tied to zero and no counter
//                   flops exist.
//
// Ports
//   iclk, irst_n            clock (rising) and async active-low reset
//   Rs1D, Rs2D              Decode source registers
//   Rs1E, Rs2E, RdE         Execute sources / destination
//   RdM, RdW                Memory / Writeback destinations
//   RegWriteM, RegWriteW    register-write enables in M and W
//   ResultSrcb0E            instruction in E is a load
//   PCSrcE                  branch/jump taken in E
//   MemReqM, DmemReadyM     data-memory request in M / access complete
//   ForwardAE, ForwardBE    00 regfile, 01 W result, 10 M ALU result
//   StallF/D/E/M            hold stage registers
//   FlushD/E/W              bubble into stage registers
//   oMemTimeout             sticky watchdog error
//   oStallCycles, oFlushCount  performance counters
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        iclk,
  input  logic        irst_n,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        ResultSrcb0E,
  input  logic        PCSrcE,
  input  logic        MemReqM,
  input  logic        DmemReadyM,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushW,
  output logic        oMemTimeout,
  output logic [31:0] oStallCycles,
  output logic [31:0] oFlushCount
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    ERROR   = 2'd2
  } state_t;

  // Counter value on the last tolerated stalled cycle of a wait.
  localparam logic [7:0] LAST_CNT = 8'(MEM_TIMEOUT - 32'd1);

  state_t      state_r;
  logic [7:0]  cnt_r;
  logic        memTimeout_r;

  logic        lwStall_s;
  logic        memStall_s;
  logic [1:0]  fwdA_s;
  logic [1:0]  fwdB_s;
  logic        stallFD_s;
  logic        flushE_s;
  logic        flushD_s;

  // M has priority over W because it holds the younger result.
  function automatic logic [1:0] fwdSel(
    input logic [4:0] rs,
    input logic [4:0] rdM,
    input logic       wrM,
    input logic [4:0] rdW,
    input logic       wrW
  );
    logic [1:0] sel;
    if (wrM && (rdM != 5'd0) && (rdM == rs)) begin
      sel = 2'b10;
    end else if (wrW && (rdW != 5'd0) && (rdW == rs)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Hazard detection: forwarding selects, load-use and memory stall terms.
  always_comb begin
    fwdA_s    = fwdSel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    fwdB_s    = fwdSel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
    lwStall_s = ResultSrcb0E && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
    case (state_r)
      RUN:     memStall_s = MemReqM && !DmemReadyM;
      MEMWAIT: memStall_s = !DmemReadyM;
      ERROR:   memStall_s = 1'b1;
      default: memStall_s = 1'b1;  // unknown encoding: freeze the pipe
    endcase
    stallFD_s = lwStall_s | memStall_s;
    // A memory stall freezes E, so any branch/load-use flush waits for release.
    if (memStall_s) begin
      flushE_s = 1'b0;
      flushD_s = 1'b0;
    end else begin
      flushE_s = lwStall_s | PCSrcE;
      flushD_s = PCSrcE;
    end
  end

  assign ForwardAE   = fwdA_s;
  assign ForwardBE   = fwdB_s;
  assign StallF      = stallFD_s;
  assign StallD      = stallFD_s;
  assign StallE      = memStall_s;
  assign StallM      = memStall_s;
  assign FlushW      = memStall_s;
  assign FlushE      = flushE_s;
  assign FlushD      = flushD_s;
  assign oMemTimeout = memTimeout_r;

  // Data-memory wait FSM with watchdog counter and sticky timeout flag.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_r      <= RUN;
      cnt_r        <= 8'd0;
      memTimeout_r <= 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          if (MemReqM && !DmemReadyM) begin
            state_r <= MEMWAIT;
            cnt_r   <= 8'd1;
          end else begin
            cnt_r   <= 8'd0;
          end
        end
        MEMWAIT: begin
          if (DmemReadyM) begin
            state_r <= RUN;
            cnt_r   <= 8'd0;
          end else if (cnt_r == LAST_CNT) begin
            state_r      <= ERROR;
            memTimeout_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        ERROR: begin
          memTimeout_r <= 1'b1;
        end
        default: begin
          state_r      <= ERROR;
          memTimeout_r <= 1'b1;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stallCycles_r;
  logic [31:0] flushCount_r;

  // Saturating performance counters for front-end stalls and D/E flushes.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      stallCycles_r <= 32'd0;
      flushCount_r  <= 32'd0;
    end else begin
      if (stallFD_s && (stallCycles_r != 32'hFFFF_FFFF)) begin
        stallCycles_r <= stallCycles_r + 32'd1;
      end
      if ((flushD_s || flushE_s) && (flushCount_r != 32'hFFFF_FFFF)) begin
        flushCount_r <= flushCount_r + 32'd1;
      end
    end
  end

  assign oStallCycles = stallCycles_r;
  assign oFlushCount  = flushCount_r;
`else
  assign oStallCycles = 32'd0;
  assign oFlushCount  = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//   Self-checking bench for hazard_ctrl (MEM_TIMEOUT = 4): a vector table for
//   forwarding/load-use/branch, hand sequences for multi-cycle corner cases,
//   and randomized stimulus against a behavioural model of the hazard rules.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int T = 4;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct {
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic       regWriteM, regWriteW, load, pcSrc, memReq, ready;
  } stim_t;

  typedef struct {
    stim_t      in;
    logic [1:0] fA, fB;
    logic       stall, flushE, flushD;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        RegWriteM, RegWriteW, ResultSrcb0E, PCSrcE, MemReqM, DmemReadyM;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic        oMemTimeout;
  logic [31:0] oStallCycles, oFlushCount;

  int nChecks = 0;
  int nBad = 0;

  // behavioural model state
  stim_t cur;
  bit    mErr, mInWait;
  int    mWaited, mStallCnt, mFlushCnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(T)) dut (
    .iclk(clk), .irst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcb0E(ResultSrcb0E), .PCSrcE(PCSrcE), .MemReqM(MemReqM),
    .DmemReadyM(DmemReadyM), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .oMemTimeout(oMemTimeout), .oStallCycles(oStallCycles), .oFlushCount(oFlushCount)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{rs1D: 5'd0, rs2D: 5'd0, rs1E: 5'd0, rs2E: 5'd0, rdE: 5'd0, rdM: 5'd0,
          rdW: 5'd0, regWriteM: 1'b0, regWriteW: 1'b0, load: 1'b0, pcSrc: 1'b0,
          memReq: 1'b0, ready: 1'b1};
    return s;
  endfunction

  function automatic logic [1:0] mFwd(input logic [4:0] rs, input stim_t s);
    if (s.regWriteM && s.rdM != 5'd0 && s.rdM == rs) return 2'b10;
    if (s.regWriteW && s.rdW != 5'd0 && s.rdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit mLw(input stim_t s);
    return s.load && s.rdE != 5'd0 && (s.rdE == s.rs1D || s.rdE == s.rs2D);
  endfunction

  // memory stalls while already waiting, on a fresh unready request, or forever after timeout
  function automatic bit mMs(input stim_t s);
    return mErr || (!s.ready && (mInWait || s.memReq));
  endfunction

  task automatic apply(input stim_t s);
    cur = s;
    Rs1D = s.rs1D; Rs2D = s.rs2D; Rs1E = s.rs1E; Rs2E = s.rs2E; RdE = s.rdE;
    RdM = s.rdM; RdW = s.rdW; RegWriteM = s.regWriteM; RegWriteW = s.regWriteW;
    ResultSrcb0E = s.load; PCSrcE = s.pcSrc; MemReqM = s.memReq; DmemReadyM = s.ready;
  endtask

  task automatic checkModel();
    bit lw, ms;
    lw = mLw(cur);
    ms = mMs(cur);
    check("ForwardAE", 32'(ForwardAE), 32'(mFwd(cur.rs1E, cur)));
    check("ForwardBE", 32'(ForwardBE), 32'(mFwd(cur.rs2E, cur)));
    check("StallF", 32'(StallF), 32'(lw | ms));
    check("StallD", 32'(StallD), 32'(lw | ms));
    check("StallE", 32'(StallE), 32'(ms));
    check("StallM", 32'(StallM), 32'(ms));
    check("FlushW", 32'(FlushW), 32'(ms));
    check("FlushE", 32'(FlushE), 32'(!ms && (lw || cur.pcSrc)));
    check("FlushD", 32'(FlushD), 32'(!ms && cur.pcSrc));
    check("oMemTimeout", 32'(oMemTimeout), 32'(mErr));
    check("oStallCycles", oStallCycles, PERF ? 32'(mStallCnt) : 32'd0);
    check("oFlushCount", oFlushCount, PERF ? 32'(mFlushCnt) : 32'd0);
  endtask

  task automatic pre(input stim_t s);
    apply(s);
    #2;
    checkModel();
  endtask

  task automatic tick();
    bit lw, ms;
    lw = mLw(cur);
    ms = mMs(cur);
    @(posedge clk);
    if (lw || ms) mStallCnt++;
    if (!ms && (lw || cur.pcSrc)) mFlushCnt++;
    if (!mErr) begin
      if (ms) begin
        mWaited++;
        if (mWaited >= T) mErr = 1'b1;
        else mInWait = 1'b1;
      end else begin
        mInWait = 1'b0;
        mWaited = 0;
      end
    end
    #1;
  endtask

  task automatic step(input stim_t s);
    pre(s);
    tick();
  endtask

  // Reset is asserted between clock edges; its effect must be visible immediately.
  task automatic doReset();
    apply(idle());
    rst_n = 1'b0;
    #1;
    mErr = 1'b0; mInWait = 1'b0; mWaited = 0; mStallCnt = 0; mFlushCnt = 0;
    check("rst_oMemTimeout", 32'(oMemTimeout), 32'd0);
    check("rst_StallF", 32'(StallF), 32'd0);
    check("rst_StallE", 32'(StallE), 32'd0);
    check("rst_oStallCycles", oStallCycles, 32'd0);
    check("rst_oFlushCount", oFlushCount, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_t  tbl[8];
    stim_t s;

    for (int i = 0; i < 8; i++) begin
      tbl[i].in = idle();
      tbl[i].fA = 2'b00; tbl[i].fB = 2'b00;
      tbl[i].stall = 1'b0; tbl[i].flushE = 1'b0; tbl[i].flushD = 1'b0;
    end
    // M and W both match: M wins
    tbl[0].in.rs1E = 5'd5; tbl[0].in.rdM = 5'd5; tbl[0].in.rdW = 5'd5;
    tbl[0].in.regWriteM = 1'b1; tbl[0].in.regWriteW = 1'b1; tbl[0].fA = 2'b10;
    // M not writing: W result
    tbl[1].in = tbl[0].in; tbl[1].in.regWriteM = 1'b0; tbl[1].fA = 2'b01;
    // x0 is never forwarded
    tbl[2].in = tbl[0].in; tbl[2].in.rdM = 5'd0; tbl[2].in.rdW = 5'd0;
    // port B from M
    tbl[3].in.rs1E = 5'd9; tbl[3].in.rs2E = 5'd7; tbl[3].in.rdM = 5'd7; tbl[3].in.rdW = 5'd7;
    tbl[3].in.regWriteM = 1'b1; tbl[3].in.regWriteW = 1'b1; tbl[3].fB = 2'b10;
    // load-use on Rs2D
    tbl[4].in.load = 1'b1; tbl[4].in.rdE = 5'd3; tbl[4].in.rs2D = 5'd3;
    tbl[4].stall = 1'b1; tbl[4].flushE = 1'b1;
    // taken branch
    tbl[5].in.pcSrc = 1'b1; tbl[5].flushE = 1'b1; tbl[5].flushD = 1'b1;
    // load into x0 is not a hazard
    tbl[6].in.load = 1'b1; tbl[6].in.rdE = 5'd0; tbl[6].in.rs1D = 5'd0;
    // port B from W when M does not write
    tbl[7].in.rs2E = 5'd4; tbl[7].in.rdM = 5'd4; tbl[7].in.rdW = 5'd4;
    tbl[7].in.regWriteW = 1'b1; tbl[7].fB = 2'b01;

    apply(idle());
    #3;
    doReset();

    for (int i = 0; i < 8; i++) begin
      pre(tbl[i].in);
      check("tbl_ForwardAE", 32'(ForwardAE), 32'(tbl[i].fA));
      check("tbl_ForwardBE", 32'(ForwardBE), 32'(tbl[i].fB));
      check("tbl_StallF", 32'(StallF), 32'(tbl[i].stall));
      check("tbl_StallD", 32'(StallD), 32'(tbl[i].stall));
      check("tbl_StallE", 32'(StallE), 32'd0);
      check("tbl_FlushE", 32'(FlushE), 32'(tbl[i].flushE));
      check("tbl_FlushD", 32'(FlushD), 32'(tbl[i].flushD));
      tick();
    end

    // performance counters: 3 load-use stalls then 2 branches
    doReset();
    s = idle(); s.load = 1'b1; s.rdE = 5'd3; s.rs1D = 5'd3;
    for (int i = 0; i < 3; i++) step(s);
    s = idle(); s.pcSrc = 1'b1;
    for (int i = 0; i < 2; i++) step(s);
    pre(idle());
    check("perf_stall", oStallCycles, PERF ? 32'd3 : 32'd0);
    check("perf_flush", oFlushCount, PERF ? 32'd5 : 32'd0);
    tick();

    // branch held in E during a 3-cycle memory wait
    s = idle(); s.pcSrc = 1'b1; s.memReq = 1'b1; s.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pre(s);
      check("br_wait_StallF", 32'(StallF), 32'd1);
      check("br_wait_StallM", 32'(StallM), 32'd1);
      check("br_wait_FlushD", 32'(FlushD), 32'd0);
      check("br_wait_FlushE", 32'(FlushE), 32'd0);
      tick();
    end
    s.ready = 1'b1;
    pre(s);
    check("br_rel_StallF", 32'(StallF), 32'd0);
    check("br_rel_FlushD", 32'(FlushD), 32'd1);
    check("br_rel_FlushE", 32'(FlushE), 32'd1);
    tick();

    // ready together with the request: no stall
    s = idle(); s.memReq = 1'b1;
    pre(s);
    check("ready_now_StallF", 32'(StallF), 32'd0);
    tick();

    // watchdog: ready never arrives
    doReset();
    s = idle(); s.memReq = 1'b1; s.ready = 1'b0;
    for (int i = 0; i < T; i++) begin
      pre(s);
      check("wd_StallE", 32'(StallE), 32'd1);
      check("wd_timeout_low", 32'(oMemTimeout), 32'd0);
      tick();
    end
    s = idle();
    pre(s);
    check("wd_timeout_set", 32'(oMemTimeout), 32'd1);
    check("wd_StallF_held", 32'(StallF), 32'd1);
    check("wd_StallM_held", 32'(StallM), 32'd1);
    tick();
    step(s);
    doReset();
    pre(idle());
    tick();

    // randomized segments; odd segments make memory slow enough to hit the watchdog
    for (int seg = 0; seg < 8; seg++) begin
      doReset();
      for (int c = 0; c < 60; c++) begin
        s.rs1D = 5'($urandom_range(0, 3)); s.rs2D = 5'($urandom_range(0, 3));
        s.rs1E = 5'($urandom_range(0, 3)); s.rs2E = 5'($urandom_range(0, 3));
        s.rdE  = 5'($urandom_range(0, 3)); s.rdM  = 5'($urandom_range(0, 3));
        s.rdW  = 5'($urandom_range(0, 3));
        s.regWriteM = 1'($urandom_range(0, 1)); s.regWriteW = 1'($urandom_range(0, 1));
        s.load  = ($urandom_range(0, 3) == 0);
        s.pcSrc = ($urandom_range(0, 3) == 0);
        s.memReq = 1'($urandom_range(0, 1));
        if (seg % 2 == 1) s.ready = ($urandom_range(0, 3) == 0);
        else              s.ready = ($urandom_range(0, 3) != 0);
        step(s);
      end
    end

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule
